// File: rtl/myfilter_pkg.sv
// Shared types and defaults for the filter datapath.
// Holds the reset-sequencer state encoding and its default timing constants.
package myfilter_pkg;

  // Reset-sequencer phases: hold everything, staged release, steady state.
  typedef enum logic [1:0] {
    RS_ASSERT  = 2'd0,
    RS_RELEASE = 2'd1,
    RS_RUN     = 2'd2
  } rstseq_state_t;

  // Default geometry of the staged reset release.
  localparam int RSTSEQ_N_DOMAINS    = 3;
  localparam int RSTSEQ_HOLD_CYCLES  = 8;
  localparam int RSTSEQ_STAGE_CYCLES = 4;

  // Larger of two integers, used to size the shared countdown timer.
  function automatic int rstseq_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : myfilter_pkg

// File: rtl/reset_sequencer.sv
// Staged reset-release controller.
// Holds every filter domain in reset for HOLD_CYCLES after the reset cause
// ends, then releases domain 0, 1, ... one at a time, STAGE_CYCLES apart.
// A software reset request (level, acknowledged by a one-cycle pulse)
// restarts the whole sequence once the release phase has begun.
module reset_sequencer
  import myfilter_pkg::*;
#(
  parameter int N_DOMAINS    = RSTSEQ_N_DOMAINS,
  parameter int HOLD_CYCLES  = RSTSEQ_HOLD_CYCLES,
  parameter int STAGE_CYCLES = RSTSEQ_STAGE_CYCLES
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 soft_req,
  output logic                 soft_ack,
  output logic [N_DOMAINS-1:0] blk_srst_n,
  output logic                 ready,
  output logic                 busy
);

  // One timer serves both the hold phase and each stage gap, so it is sized
  // for the larger of the two; it is always reloaded before reaching zero
  // wraps, so it never underflows.
  localparam int TMR_MAX = rstseq_max(HOLD_CYCLES, STAGE_CYCLES);
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int IDX_W   = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  localparam logic [TMR_W-1:0] HOLD_INIT  = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] STAGE_INIT = TMR_W'(STAGE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_DOMAINS - 1);

  // Parameter sanity, rejected at elaboration time.
  if (N_DOMAINS < 1) begin : g_bad_n_domains
    $error("reset_sequencer: N_DOMAINS must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
    $error("reset_sequencer: HOLD_CYCLES must be >= 1");
  end
  if (STAGE_CYCLES < 1) begin : g_bad_stage_cycles
    $error("reset_sequencer: STAGE_CYCLES must be >= 1");
  end

  rstseq_state_t        state_q,    state_d;
  logic [TMR_W-1:0]     timer_q,    timer_d;
  logic [IDX_W-1:0]     idx_q,      idx_d;
  logic [IDX_W-1:0]     idx_inc;
  logic [N_DOMAINS-1:0] blk_n_q,    blk_n_d;
  logic                 ready_q,    ready_d;
  logic                 busy_q,     busy_d;
  logic                 soft_ack_q, soft_ack_d;

  assign idx_inc = idx_q + IDX_W'(1);

  // Next-state logic: hold countdown, staged release, and soft-reset restart.
  always_comb begin
    // NOTE: every _d gets a default before the case so no path can infer a latch.
    state_d    = state_q;
    timer_d    = timer_q;
    idx_d      = idx_q;
    blk_n_d    = blk_n_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    soft_ack_d = 1'b0;

    unique case (state_q)
      RS_ASSERT: begin
        // soft_req is deliberately not looked at here: the sequence is
        // already restarting, so a held request waits for RS_RELEASE.
        if (timer_q == '0) begin
          blk_n_d = N_DOMAINS'(1);
          timer_d = STAGE_INIT;
          if (N_DOMAINS == 1) begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
            state_d = RS_RUN;
          end else begin
            state_d = RS_RELEASE;
          end
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

      RS_RELEASE: begin
        if (soft_req) begin
          state_d    = RS_ASSERT;
          timer_d    = HOLD_INIT;
          idx_d      = '0;
          blk_n_d    = '0;
          ready_d    = 1'b0;
          busy_d     = 1'b1;
          soft_ack_d = 1'b1;
        end else if (timer_q == '0) begin
          // Domains release strictly in index order, so shifting in a one
          // releases exactly domain idx+1 while keeping earlier ones released.
          blk_n_d = (blk_n_q << 1) | N_DOMAINS'(1);
          idx_d   = idx_inc;
          if (idx_inc == LAST_IDX) begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
            state_d = RS_RUN;
          end else begin
            timer_d = STAGE_INIT;
          end
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

      RS_RUN: begin
        if (soft_req) begin
          state_d    = RS_ASSERT;
          timer_d    = HOLD_INIT;
          idx_d      = '0;
          blk_n_d    = '0;
          ready_d    = 1'b0;
          busy_d     = 1'b1;
          soft_ack_d = 1'b1;
        end
      end

      default: begin
        // Unreachable encoding: fall back to a full reset of all domains.
        state_d = RS_ASSERT;
        timer_d = HOLD_INIT;
        idx_d   = '0;
        blk_n_d = '0;
        ready_d = 1'b0;
        busy_d  = 1'b1;
      end
    endcase
  end

  // State and output registers; srst forces the full-assert reset values.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (srst) begin
      state_q    <= RS_ASSERT;
      timer_q    <= HOLD_INIT;
      idx_q      <= '0;
      blk_n_q    <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b1;
      soft_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      blk_n_q    <= blk_n_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      soft_ack_q <= soft_ack_d;
    end
  end

  assign blk_srst_n = blk_n_q;
  assign ready      = ready_q;
  assign busy       = busy_q;
  assign soft_ack   = soft_ack_q;

endmodule : reset_sequencer

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a default-parameter instance and a minimal
// corner instance (1 domain, 1-cycle hold, 1-cycle stage) share the same
// srst/soft_req stimulus. A per-edge reference model derives each instance's
// expected outputs from the release-time formula and queues them; a monitor
// on the falling edge pops and compares against what the DUT shows.
module tb_reset_sequencer;

  typedef struct packed {
    logic [7:0] blk;
    logic       ready;
    logic       busy;
    logic       ack;
  } exp_t;

  logic       clk;
  logic       srst;
  logic       soft_req;
  logic       soft_ack_a, ready_a, busy_a;
  logic [2:0] blk_a;
  logic       soft_ack_b, ready_b, busy_b;
  logic [0:0] blk_b;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  bit   valid_a = 1'b0, valid_b = 1'b0;
  int   e0_a = 0, e0_b = 0;

  reset_sequencer #(.N_DOMAINS(3), .HOLD_CYCLES(8), .STAGE_CYCLES(4)) u_dut_a (
    .clk        (clk),
    .srst       (srst),
    .soft_req   (soft_req),
    .soft_ack   (soft_ack_a),
    .blk_srst_n (blk_a),
    .ready      (ready_a),
    .busy       (busy_a)
  );

  reset_sequencer #(.N_DOMAINS(1), .HOLD_CYCLES(1), .STAGE_CYCLES(1)) u_dut_b (
    .clk        (clk),
    .srst       (srst),
    .soft_req   (soft_req),
    .soft_ack   (soft_ack_b),
    .blk_srst_n (blk_b),
    .ready      (ready_b),
    .busy       (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference behaviour at edge t. e0 is the first edge after the reset
  // cause ends; domain i is released by edge e0+h-1+i*s; a soft request is
  // honoured once domain 0 has been released (edge >= e0+h).
  function automatic void model_step(input bit srst_i, input bit soft_i, input int t,
                                     input int n, input int h, input int s,
                                     inout bit valid, inout int e0, output exp_t e);
    int cnt;
    e = '0;
    if (srst_i) begin
      valid = 1'b1;
      e0    = t + 1;
      e.busy = 1'b1;
    end else if (valid) begin
      if (soft_i && t >= e0 + h) begin
        e0     = t + 1;
        e.busy = 1'b1;
        e.ack  = 1'b1;
      end else begin
        cnt = 0;
        for (int i = 0; i < n; i++)
          if (t >= e0 + h - 1 + i * s) cnt++;
        e.blk   = 8'((1 << cnt) - 1);
        e.ready = (cnt == n);
        e.busy  = (cnt != n);
      end
    end
  endfunction

  // Model: sample the inputs the DUTs see at this edge and queue expectations.
  always @(posedge clk) begin
    exp_t ea, eb;
    cyc++;
    model_step(srst, soft_req, cyc, 3, 8, 4, valid_a, e0_a, ea);
    model_step(srst, soft_req, cyc, 1, 1, 1, valid_b, e0_b, eb);
    if (valid_a) q_a.push_back(ea);
    if (valid_b) q_b.push_back(eb);
  end

  // Monitor: compare whatever the DUTs present against the queued model output.
  always @(negedge clk) begin
    exp_t ea, eb;
    if (q_a.size() > 0) begin
      ea = q_a.pop_front();
      check("out_a{blk,ready,busy,ack}", {21'd0, 5'd0, blk_a, ready_a, busy_a, soft_ack_a},
            {21'd0, ea});
    end
    if (q_b.size() > 0) begin
      eb = q_b.pop_front();
      check("out_b{blk,ready,busy,ack}", {21'd0, 7'd0, blk_b, ready_b, busy_b, soft_ack_b},
            {21'd0, eb});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Hold soft_req until instance A acknowledges it, bounded.
  task automatic soft_until_ack(input int budget);
    bit got;
    got = 1'b0;
    soft_req = 1'b1;
    for (int n = 0; n < budget; n++) begin
      tick();
      if (soft_ack_a) begin
        got = 1'b1;
        break;
      end
    end
    soft_req = 1'b0;
    check("soft_ack_arrives", 32'(got), 32'd1);
  endtask

  initial begin
    int k;
    srst     = 1'b1;
    soft_req = 1'b0;

    // Power-on: 3 reset cycles, then measure edges from e0 to ready.
    repeat (3) tick();
    srst = 1'b0;
    @(posedge clk);
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      if (ready_a) break;
      @(posedge clk);
      k++;
    end
    check("poweron_ready_edge", 32'(k), 32'd15);

    // Soft reset in RS_RUN, request held for two cycles.
    soft_req = 1'b1;
    repeat (2) tick();
    soft_req = 1'b0;
    repeat (20) tick();

    // Soft reset during RS_RELEASE, then held through RS_ASSERT.
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    repeat (10) tick();
    soft_until_ack(40);
    soft_until_ack(40);

    // srst mid-sequence with domains 0 and 1 released.
    repeat (14) tick();
    srst = 1'b1;
    repeat (2) tick();
    srst = 1'b0;
    repeat (20) tick();

    // Simultaneous srst and soft_req.
    srst     = 1'b1;
    soft_req = 1'b1;
    tick();
    srst     = 1'b0;
    soft_req = 1'b0;
    repeat (25) tick();

    // Randomized mix of resets, handshaked and short soft requests, idle gaps.
    for (int it = 0; it < 1500; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 5) begin
        srst = 1'b1;
        if ($urandom_range(0, 3) == 0) soft_req = 1'b1;
        repeat ($urandom_range(1, 4)) tick();
        srst     = 1'b0;
        soft_req = 1'b0;
      end else if (r < 20) begin
        soft_until_ack(60);
      end else if (r < 30) begin
        soft_req = 1'b1;
        repeat ($urandom_range(1, 3)) tick();
        soft_req = 1'b0;
      end else begin
        repeat ($urandom_range(1, 10)) tick();
      end
    end

    srst     = 1'b0;
    soft_req = 1'b0;
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_reset_sequencer
